butterfly_radix4_stream: RTL and testbench
==========================================

Name: butterfly_radix4_stream

Overview:
- Parametrised, stallable radix-4 DIT butterfly for the radix-4 SDF FFT datapath.
- Multiplies b, c, d by caller-supplied twiddles and forms the four radix-4 outputs.
- Adds the following over the fixed-latency butterfly: valid/ready backpressure, per-beat forward/inverse mode, per-beat output scaling with rounding, saturation with flags, and a `last` tag carried alongside the data.

Parameters:
- WIDTH, 16, signed width of each data component (input and output).
- TW_WIDTH, 16, signed twiddle component width, format Q1.(TW_WIDTH-1).
- ROUND, 1, 1 = round-half-up at every shift point; 0 = truncate (arithmetic shift).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_last  in  1  tag, delivered unchanged on out_last.
- in_inverse  in  1  0 = forward kernel, 1 = inverse kernel.
- in_shift  in  2  output right-shift: 0, 1 or 2; value 3 is treated as 2.
- ar, ai, br, bi, cr, ci, dr, di  in  WIDTH each  signed inputs a, b, c, d.
- w0r, w0i, w1r, w1i, w2r, w2i  in  TW_WIDTH each  twiddles; w0 applies to b, w1 to c, w2 to d.
- out1r, out1i, out2r, out2i, out3r, out3i, out4r, out4i  out  WIDTH each  registered outputs.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  tag aligned with the output beat.
- out_sat  out  1  at least one component of this beat saturated.
- sat_sticky  out  1  OR of out_sat over all delivered beats since reset or clear.
- clear_sat  in  1  synchronous clear of sat_sticky.

Behaviour:
- Reset: reset_n low asynchronously clears every pipeline register. All outputs, out_valid, out_last, out_sat and sat_sticky read 0.
- Reset mid-operation: all in-flight beats are discarded. No stale beat appears after reset_n is released.
- Pipeline: five stages with a common enable, en = !out_valid || out_ready.
  - S0: input register.
  - S1: twelve partial products.
  - S2: complex products m0..m2.
  - S3: t0..t3.
  - S4: output.
- in_ready = en, which is combinational from out_valid and out_ready.
- A beat is accepted when in_valid && in_ready. It appears on the outputs after 5 enabled edges.
- When en = 0 every register holds. Outputs stay stable while out_valid && !out_ready.
- Bubbles travel with the data; they are not collapsed.
- Per-stage valid, last, inverse and shift bits travel with the data.
- Products:
  - m0 = b*w0, with mr = br*wr - bi*wi and mi = br*wi + bi*wr; m1 and m2 are formed the same way from c, w1 and d, w2.
  - Full product width is WIDTH+TW_WIDTH.
  - Each product is rescaled by >> (TW_WIDTH-1) to WIDTH+1 bits. When ROUND = 1, 2^(TW_WIDTH-2) is added before the shift.
- Butterfly sums:
  - t0 = a + m1, t1 = a - m1, t2 = m0 + m2, t3 = m0 - m2.
  - All t values are held at WIDTH+2 bits and all outputs at WIDTH+3 bits internally, so no wrap occurs before saturation.
- Outputs, forward mode:
  - out1 = t0 + t2
  - out2 = t1 - j·t3, i.e. re = t1r + t3i, im = t1i - t3r
  - out3 = t0 - t2
  - out4 = t1 + j·t3
- Outputs, inverse mode: out2 and out4 swap formulas. The caller supplies conjugated twiddles.
- Output scaling:
  - Each internal output is shifted arithmetically right by the beat's shift value.
  - When ROUND = 1, 2^(shift-1) is added first if shift > 0.
  - The result is then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Saturation flags:
  - out_sat = OR over the 8 components of the beat.
  - sat_sticky sets on a beat handshake (out_valid && out_ready && out_sat).
  - clear_sat clears sat_sticky on the next edge. If clear and set happen in the same cycle, set wins.
- Boundaries:
  - in_shift = 3 is handled exactly as 2.
  - -2^(WIDTH-1) inputs are legal; saturation covers them.
  - Twiddle -1.0 is legal; +1.0 is not representable.

Test Plan:
1. WIDTH=16, ROUND=1. a=b=c=d=(1000,0), all w=(0x7FFF,0), forward, shift 0 → out1=(4000,0); out2, out3, out4 = (0,0); out_sat=0; out_valid exactly 5 cycles after acceptance.
2. a=c=d=0, b=(0,1000), w0=(0x7FFF,0).
   - Forward → out1=(0,1000), out2=(1000,0), out3=(0,-1000), out4=(-1000,0).
   - Inverse → out2=(-1000,0), out4=(1000,0); out1 and out3 unchanged.
3. a=b=c=d=(30000,0), w=(0x7FFF,0).
   - shift 0 → out1r=32767, out_sat=1, sat_sticky=1 after handshake.
   - shift 2 → out1r=29999, out_sat=0.
   - Pulse clear_sat → sat_sticky=0.
4. Stream 10 beats with in_last on beat 10; hold out_ready=0 for 7 cycles starting at cycle 6.
   - in_ready=0 while stalled and outputs held stable.
   - All 10 beats delivered in order, none lost or duplicated; out_last only on beat 10.
5. Build inputs giving internal out1r=3 and -3 with shift 1.
   - ROUND=1 → 2 and -1.
   - ROUND=0 → 1 and -2.
6. Assert reset_n low for 1 cycle with 3 beats in flight and out_ready=0 → out_valid=0 and outputs 0 immediately; no beats emerge after release; sat_sticky=0.

Source files
------------

// File: rtl/butterfly_radix4_stream.sv
// Stallable radix-4 DIT butterfly: twiddle multiply of b/c/d, radix-4 combine,
// per-beat forward/inverse, rounding shift, saturation flags and a last tag.
module butterfly_radix4_stream #(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int ROUND    = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic                       in_inverse,
  input  logic [1:0]                 in_shift,
  input  logic signed [WIDTH-1:0]    ar, ai, br, bi, cr, ci, dr, di,
  input  logic signed [TW_WIDTH-1:0] w0r, w0i, w1r, w1i, w2r, w2i,
  output logic signed [WIDTH-1:0]    out1r, out1i, out2r, out2i,
  output logic signed [WIDTH-1:0]    out3r, out3i, out4r, out4i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       out_sat,
  output logic                       sat_sticky,
  input  logic                       clear_sat
);

  localparam int PW  = WIDTH + TW_WIDTH;
  localparam int MW  = WIDTH + 1;
  localparam int TWW = WIDTH + 2;
  localparam int OW  = WIDTH + 3;
  localparam logic signed [OW:0] SMAX = (OW+1)'(2**(WIDTH-1) - 1);
  localparam logic signed [OW:0] SMIN = ~SMAX;

  logic                       en;
  logic                       v_q    [4];
  logic                       last_q [4];
  logic                       inv_q  [4];
  logic [1:0]                 sh_q   [4];
  logic signed [WIDTH-1:0]    x_q    [8];
  logic signed [TW_WIDTH-1:0] w_q    [6];
  logic signed [PW-1:0]       pp_q   [12];
  logic signed [WIDTH-1:0]    s1a_q  [2];
  logic signed [MW-1:0]       m_q    [6];
  logic signed [MW-1:0]       m_d    [6];
  logic signed [WIDTH-1:0]    s2a_q  [2];
  logic signed [TWW-1:0]      t_q    [8];
  logic signed [TWW-1:0]      t_d    [8];
  logic signed [WIDTH-1:0]    out_q  [8];
  logic signed [WIDTH-1:0]    y_d    [8];
  logic                       out_valid_q, out_last_q, out_sat_q, sat_d;
  logic                       sticky_q, sticky_d;

  logic signed [PW:0]         rnd_m, mr, mi;
  logic signed [OW-1:0]       o_d [8];
  logic signed [OW:0]         rnd_o, sc;
  logic [1:0]                 sh_eff;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Complex products rescaled from Q1.(TW_WIDTH-1); the extra top bit keeps the
  // difference of two full-width products from wrapping before the shift.
  always_comb begin
    rnd_m = '0;
    if (ROUND != 0) rnd_m[TW_WIDTH-2] = 1'b1;
    mr = '0;
    mi = '0;
    m_d = '{default: '0};
    for (int unsigned k = 0; k < 3; k++) begin
      mr = (PW+1)'(pp_q[4*k])   - (PW+1)'(pp_q[4*k+1]) + rnd_m;
      mi = (PW+1)'(pp_q[4*k+2]) + (PW+1)'(pp_q[4*k+3]) + rnd_m;
      m_d[2*k]   = MW'(mr >>> (TW_WIDTH-1));
      m_d[2*k+1] = MW'(mi >>> (TW_WIDTH-1));
    end
  end

  always_comb begin
    t_d[0] = TWW'(s2a_q[0]) + TWW'(m_q[2]);
    t_d[1] = TWW'(s2a_q[1]) + TWW'(m_q[3]);
    t_d[2] = TWW'(s2a_q[0]) - TWW'(m_q[2]);
    t_d[3] = TWW'(s2a_q[1]) - TWW'(m_q[3]);
    t_d[4] = TWW'(m_q[0]) + TWW'(m_q[4]);
    t_d[5] = TWW'(m_q[1]) + TWW'(m_q[5]);
    t_d[6] = TWW'(m_q[0]) - TWW'(m_q[4]);
    t_d[7] = TWW'(m_q[1]) - TWW'(m_q[5]);
  end

  always_comb begin
    o_d[0] = OW'(t_q[0]) + OW'(t_q[4]);
    o_d[1] = OW'(t_q[1]) + OW'(t_q[5]);
    o_d[2] = OW'(t_q[2]) + OW'(t_q[7]);
    o_d[3] = OW'(t_q[3]) - OW'(t_q[6]);
    o_d[4] = OW'(t_q[0]) - OW'(t_q[4]);
    o_d[5] = OW'(t_q[1]) - OW'(t_q[5]);
    o_d[6] = OW'(t_q[2]) - OW'(t_q[7]);
    o_d[7] = OW'(t_q[3]) + OW'(t_q[6]);
    if (inv_q[3]) begin
      o_d[2] = OW'(t_q[2]) - OW'(t_q[7]);
      o_d[3] = OW'(t_q[3]) + OW'(t_q[6]);
      o_d[6] = OW'(t_q[2]) + OW'(t_q[7]);
      o_d[7] = OW'(t_q[3]) - OW'(t_q[6]);
    end
    sh_eff = (sh_q[3] == 2'd3) ? 2'd2 : sh_q[3];
    rnd_o  = '0;
    if (ROUND != 0 && sh_eff != 2'd0) rnd_o = (OW+1)'(1) << (sh_eff - 2'd1);
    sc    = '0;
    sat_d = 1'b0;
    y_d   = '{default: '0};
    for (int unsigned i = 0; i < 8; i++) begin
      sc = ((OW+1)'(o_d[i]) + rnd_o) >>> sh_eff;
      if (sc > SMAX) begin
        y_d[i] = WIDTH'(SMAX);
        sat_d  = 1'b1;
      end else if (sc < SMIN) begin
        y_d[i] = WIDTH'(SMIN);
        sat_d  = 1'b1;
      end else begin
        y_d[i] = WIDTH'(sc);
      end
    end
  end

  // Set wins over clear when both land in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (clear_sat) sticky_d = 1'b0;
    if (out_valid_q && out_ready && out_sat_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q         <= '{default: '0};
      last_q      <= '{default: '0};
      inv_q       <= '{default: '0};
      sh_q        <= '{default: '0};
      x_q         <= '{default: '0};
      w_q         <= '{default: '0};
      pp_q        <= '{default: '0};
      s1a_q       <= '{default: '0};
      m_q         <= '{default: '0};
      s2a_q       <= '{default: '0};
      t_q         <= '{default: '0};
      out_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      if (en) begin
        v_q[0]    <= in_valid;
        last_q[0] <= in_last;
        inv_q[0]  <= in_inverse;
        sh_q[0]   <= in_shift;
        for (int unsigned s = 1; s < 4; s++) begin
          v_q[s]    <= v_q[s-1];
          last_q[s] <= last_q[s-1];
          inv_q[s]  <= inv_q[s-1];
          sh_q[s]   <= sh_q[s-1];
        end
        x_q <= '{ar, ai, br, bi, cr, ci, dr, di};
        w_q <= '{w0r, w0i, w1r, w1i, w2r, w2i};
        for (int unsigned k = 0; k < 3; k++) begin
          pp_q[4*k]   <= PW'(x_q[2*k+2]) * PW'(w_q[2*k]);
          pp_q[4*k+1] <= PW'(x_q[2*k+3]) * PW'(w_q[2*k+1]);
          pp_q[4*k+2] <= PW'(x_q[2*k+2]) * PW'(w_q[2*k+1]);
          pp_q[4*k+3] <= PW'(x_q[2*k+3]) * PW'(w_q[2*k]);
        end
        s1a_q       <= '{x_q[0], x_q[1]};
        m_q         <= m_d;
        s2a_q       <= s1a_q;
        t_q         <= t_d;
        out_q       <= y_d;
        out_valid_q <= v_q[3];
        out_last_q  <= last_q[3];
        out_sat_q   <= sat_d;
      end
    end
  end

  assign out1r      = out_q[0];
  assign out1i      = out_q[1];
  assign out2r      = out_q[2];
  assign out2i      = out_q[3];
  assign out3r      = out_q[4];
  assign out3i      = out_q[5];
  assign out4r      = out_q[6];
  assign out4i      = out_q[7];
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_sat    = out_sat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_butterfly_radix4_stream.sv
// Bench for butterfly_radix4_stream: ROUND=1 and ROUND=0 instances share stimulus
// and are scored against an integer model of the radix-4 butterfly.
module tb_butterfly_radix4_stream;
  localparam int W  = 16;
  localparam int TW = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic in_valid = 1'b0, in_last = 1'b0, in_inverse = 1'b0;
  logic out_ready = 1'b0, clear_sat = 1'b0;
  logic [1:0] in_shift = 2'd0;
  logic signed [W-1:0]  x [8];
  logic signed [TW-1:0] w [6];
  logic signed [W-1:0]  ya [8];
  logic signed [W-1:0]  yb [8];
  logic rdy_a, rdy_b, ova, ovb, la, lb, sa, sb, ska, skb;

  butterfly_radix4_stream #(.WIDTH(W), .TW_WIDTH(TW), .ROUND(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_last(in_last), .in_inverse(in_inverse), .in_shift(in_shift),
    .ar(x[0]), .ai(x[1]), .br(x[2]), .bi(x[3]), .cr(x[4]), .ci(x[5]), .dr(x[6]), .di(x[7]),
    .w0r(w[0]), .w0i(w[1]), .w1r(w[2]), .w1i(w[3]), .w2r(w[4]), .w2i(w[5]),
    .out1r(ya[0]), .out1i(ya[1]), .out2r(ya[2]), .out2i(ya[3]),
    .out3r(ya[4]), .out3i(ya[5]), .out4r(ya[6]), .out4i(ya[7]),
    .out_valid(ova), .out_ready(out_ready), .out_last(la), .out_sat(sa),
    .sat_sticky(ska), .clear_sat(clear_sat));

  butterfly_radix4_stream #(.WIDTH(W), .TW_WIDTH(TW), .ROUND(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_last(in_last), .in_inverse(in_inverse), .in_shift(in_shift),
    .ar(x[0]), .ai(x[1]), .br(x[2]), .bi(x[3]), .cr(x[4]), .ci(x[5]), .dr(x[6]), .di(x[7]),
    .w0r(w[0]), .w0i(w[1]), .w1r(w[2]), .w1i(w[3]), .w2r(w[4]), .w2i(w[5]),
    .out1r(yb[0]), .out1i(yb[1]), .out2r(yb[2]), .out2i(yb[3]),
    .out3r(yb[4]), .out3i(yb[5]), .out4r(yb[6]), .out4i(yb[7]),
    .out_valid(ovb), .out_ready(out_ready), .out_last(lb), .out_sat(sb),
    .sat_sticky(skb), .clear_sat(clear_sat));

  typedef struct packed {
    logic [7:0][15:0] x;
    logic [5:0][15:0] w;
    logic             last;
    logic             inv;
    logic [1:0]       sh;
  } beat_t;

  typedef struct packed {
    logic [7:0][15:0] o;
    logic             sat;
  } exp_t;

  beat_t q[$];
  beat_t cur;
  int nchk = 0, nerr = 0, ndel = 0;
  bit acc = 1'b0, stk_a = 1'b0, stk_b = 1'b0, sb_en = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input beat_t b, input bit rnd);
    exp_t e;
    longint m[6];
    longint t[8];
    longint o[8];
    longint xr, xi, wr, wi, re, im, v, tmp;
    int sh;
    for (int k = 0; k < 3; k++) begin
      xr = $signed(b.x[2+2*k]);
      xi = $signed(b.x[3+2*k]);
      wr = $signed(b.w[2*k]);
      wi = $signed(b.w[2*k+1]);
      re = xr * wr - xi * wi;
      im = xr * wi + xi * wr;
      if (rnd) begin
        re += longint'(1) << (TW-2);
        im += longint'(1) << (TW-2);
      end
      m[2*k]   = re >>> (TW-1);
      m[2*k+1] = im >>> (TW-1);
    end
    xr = $signed(b.x[0]);
    xi = $signed(b.x[1]);
    t[0] = xr + m[2];   t[1] = xi + m[3];
    t[2] = xr - m[2];   t[3] = xi - m[3];
    t[4] = m[0] + m[4]; t[5] = m[1] + m[5];
    t[6] = m[0] - m[4]; t[7] = m[1] - m[5];
    o[0] = t[0] + t[4]; o[1] = t[1] + t[5];
    o[2] = t[2] + t[7]; o[3] = t[3] - t[6];
    o[4] = t[0] - t[4]; o[5] = t[1] - t[5];
    o[6] = t[2] - t[7]; o[7] = t[3] + t[6];
    if (b.inv) begin
      tmp = o[2]; o[2] = o[6]; o[6] = tmp;
      tmp = o[3]; o[3] = o[7]; o[7] = tmp;
    end
    sh = (b.sh > 2) ? 2 : int'(b.sh);
    e.sat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = o[i];
      if (rnd && sh > 0) v += longint'(1) << (sh-1);
      v = v >>> sh;
      if (v > 32767) begin v = 32767; e.sat = 1'b1; end
      else if (v < -32768) begin v = -32768; e.sat = 1'b1; end
      e.o[i] = 16'(v);
    end
    return e;
  endfunction

  function automatic beat_t mk(input int a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i,
                               input int w_r, w_i, input bit inv, input int sh);
    beat_t b;
    b.x[0] = 16'(a_r); b.x[1] = 16'(a_i); b.x[2] = 16'(b_r); b.x[3] = 16'(b_i);
    b.x[4] = 16'(c_r); b.x[5] = 16'(c_i); b.x[6] = 16'(d_r); b.x[7] = 16'(d_i);
    for (int i = 0; i < 3; i++) begin
      b.w[2*i]   = 16'(w_r);
      b.w[2*i+1] = 16'(w_i);
    end
    b.last = 1'b0;
    b.inv  = inv;
    b.sh   = 2'(sh);
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    int sel;
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      b.x[i] = 16'h8000;
      else if (sel < 5)  b.x[i] = 16'($urandom_range(0, 4000)) - 16'd2000;
      else               b.x[i] = 16'($urandom);
    end
    for (int i = 0; i < 6; i++)
      b.w[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    b.last = 1'($urandom);
    b.inv  = 1'($urandom);
    b.sh   = 2'($urandom);
    return b;
  endfunction

  task automatic drive(input beat_t b);
    cur = b;
    for (int i = 0; i < 8; i++) x[i] = b.x[i];
    for (int i = 0; i < 6; i++) w[i] = b.w[i];
    in_last    = b.last;
    in_inverse = b.inv;
    in_shift   = b.sh;
  endtask

  // Checks mid-cycle against the head of the scoreboard, then advances one clock.
  task automatic tick();
    exp_t ea, eb;
    bit del;
    #1;
    acc = in_valid && rdy_a;
    ea = '0;
    eb = '0;
    if (sb_en) begin
      if (q.size() > 0) begin
        ea = model(q[0], 1'b1);
        eb = model(q[0], 1'b0);
      end
      if (ova && !out_ready) begin
        chk("stall_ready_a", rdy_a, 0);
        chk("stall_ready_b", rdy_b, 0);
      end
      if (q.size() == 0) begin
        chk("unexpected_valid_a", ova, 0);
        chk("unexpected_valid_b", ovb, 0);
      end else if (ova || ovb) begin
        chk("valid_b", ovb, ova);
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("r1_out%0d", i), ya[i], $signed(ea.o[i]));
          chk($sformatf("r0_out%0d", i), yb[i], $signed(eb.o[i]));
        end
        chk("r1_last", la, q[0].last);
        chk("r0_last", lb, q[0].last);
        chk("r1_sat", sa, ea.sat);
        chk("r0_sat", sb, eb.sat);
      end
      chk("r1_sticky", ska, stk_a);
      chk("r0_sticky", skb, stk_b);
      del = ova && out_ready && (q.size() > 0);
      stk_a = (del && ea.sat) ? 1'b1 : (clear_sat ? 1'b0 : stk_a);
      stk_b = (del && eb.sat) ? 1'b1 : (clear_sat ? 1'b0 : stk_b);
      if (del) begin
        void'(q.pop_front());
        ndel++;
      end
      if (acc) q.push_back(cur);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_one(input beat_t b);
    int n;
    drive(b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!ova && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, 5);
  endtask

  task automatic chk_vec(input string tag, input int e[8]);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_%0d", tag, i), ya[i], e[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[8];
    int sent, ndel0;
    beat_t b;

    for (int i = 0; i < 8; i++) x[i] = '0;
    for (int i = 0; i < 6; i++) w[i] = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 8; i++) chk($sformatf("reset_out%0d", i), ya[i], 0);
    chk("reset_valid", ova, 0);
    chk("reset_last", la, 0);
    chk("reset_sat", sa, 0);
    chk("reset_sticky", ska, 0);
    reset_n = 1'b1;
    sb_en   = 1'b1;
    @(negedge clock);

    run_one(mk(1000, 0, 1000, 0, 1000, 0, 1000, 0, 32767, 0, 1'b0, 0));
    e = '{4000, 0, 0, 0, 0, 0, 0, 0};
    chk_vec("dc", e);
    chk("dc_sat", sa, 0);
    tick();

    run_one(mk(0, 0, 0, 1000, 0, 0, 0, 0, 32767, 0, 1'b0, 0));
    e = '{0, 1000, 1000, 0, 0, -1000, -1000, 0};
    chk_vec("fwd_b", e);
    tick();
    run_one(mk(0, 0, 0, 1000, 0, 0, 0, 0, 32767, 0, 1'b1, 0));
    e = '{0, 1000, -1000, 0, 0, -1000, 1000, 0};
    chk_vec("inv_b", e);
    tick();

    run_one(mk(30000, 0, 30000, 0, 30000, 0, 30000, 0, 32767, 0, 1'b0, 0));
    chk("sat_out1r", ya[0], 32767);
    chk("sat_flag", sa, 1);
    tick();
    chk("sat_sticky_set", ska, 1);
    run_one(mk(30000, 0, 30000, 0, 30000, 0, 30000, 0, 32767, 0, 1'b0, 2));
    chk("shift2_out1r", ya[0], 29999);
    chk("shift2_sat", sa, 0);
    tick();
    run_one(mk(30000, 0, 30000, 0, 30000, 0, 30000, 0, 32767, 0, 1'b0, 3));
    chk("shift3_out1r", ya[0], 29999);
    tick();
    clear_sat = 1'b1;
    tick();
    clear_sat = 1'b0;
    chk("sticky_cleared", ska, 0);

    run_one(mk(3, 0, 0, 0, 0, 0, 0, 0, 32767, 0, 1'b0, 1));
    chk("rnd_pos_r1", ya[0], 2);
    chk("rnd_pos_r0", yb[0], 1);
    tick();
    run_one(mk(-3, 0, 0, 0, 0, 0, 0, 0, 32767, 0, 1'b0, 1));
    chk("rnd_neg_r1", ya[0], -1);
    chk("rnd_neg_r0", yb[0], -2);
    tick();

    sent  = 0;
    ndel0 = ndel;
    for (int c = 0; c < 60; c++) begin
      if (sent < 10) begin
        b = rand_beat();
        b.last = (sent == 9);
        drive(b);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(c >= 6 && c < 13);
      tick();
      if (acc) sent++;
    end
    chk("stream_delivered", ndel - ndel0, 10);
    chk("stream_queue_empty", q.size(), 0);

    for (int c = 0; c < 400; c++) begin
      drive(rand_beat());
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      clear_sat = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid  = 1'b0;
    clear_sat = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("random_queue_empty", q.size(), 0);

    run_one(mk(30000, 0, 30000, 0, 30000, 0, 30000, 0, 32767, 0, 1'b0, 0));
    tick();
    chk("pre_reset_sticky", ska, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin
      drive(mk(100, 0, 100, 0, 100, 0, 100, 0, 32767, 0, 1'b0, 0));
      tick();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midreset_valid", ova, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("midreset_out%0d", i), ya[i], 0);
    chk("midreset_sticky", ska, 0);
    chk("midreset_sat", sa, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    q.delete();
    stk_a = 1'b0;
    stk_b = 1'b0;
    ndel0 = ndel;
    out_ready = 1'b1;
    repeat (12) tick();
    chk("post_reset_no_beats", ndel - ndel0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
